// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared declarations for the instruction-fetch stage:
//   fetch_state_e : fetch controller states
//   NOP_INSTR     : instruction word presented while no instruction is valid
//                   (sll $0,$0,0)
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_ERR
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// Counts cycles spent waiting for an instruction-memory response and flags
// expiry on the TIMEOUT-th waiting cycle. TIMEOUT=0 disables the watchdog.
//
// Ports:
//   clk       in  1  rising-edge clock
//   rst_n     in  1  asynchronous active-low reset
//   i_clear   in  1  restart the count (asserted on entry to the wait phase)
//   i_enable  in  1  the fetch stage is currently waiting
//   o_expired out 1  this is the TIMEOUT-th consecutive waiting cycle
// ---------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] SAT  = TIMEOUT[CNT_W-1:0];

    // r_cnt holds the number of waiting cycles already completed, so the
    // current cycle is number r_cnt+1.
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != SAT)) begin
            // saturate instead of wrapping so a stuck wait cannot look fresh
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && i_enable && (r_cnt >= LAST);

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage sitting after the program-counter block. Fetches the
// word at the current PC over a request/grant/response memory interface,
// hands it to decode with a valid/ready handshake and pulses pc_en once per
// accepted instruction. Redirects (flush) discard stale responses; misaligned
// PCs and response timeouts park the stage in a sticky error state.
//
// Ports:
//   clk          in  1       rising-edge clock
//   rst_n        in  1       asynchronous active-low reset
//   direinstrux  in  ADDR_W  current PC from the pc block
//   flush        in  1       PC redirected this cycle; drop in-flight fetch
//   pc_en        out 1       one-cycle PC advance enable
//   imem_req     out 1       fetch request
//   imem_addr    out ADDR_W  fetch address
//   imem_gnt     in  1       memory accepts the request
//   imem_rvalid  in  1       response data valid
//   imem_rdata   in  DATA_W  response data
//   instr        out DATA_W  fetched instruction (RESET_INSTR while invalid)
//   instr_pc     out ADDR_W  address of instr
//   instr_valid  out 1       instr/instr_pc valid
//   instr_ready  in  1       decode accepts instr
//   fetch_err    out 1       sticky error (misaligned or timeout)
// ---------------------------------------------------------------------------
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT     = 15,
    parameter logic [DATA_W-1:0] RESET_INSTR = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] direinstrux,
    input  logic              flush,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic              r_drop;
    logic              w_drop_nxt;
    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;

    logic              w_misaligned;
    logic              w_accept;
    logic              w_capture;
    logic              w_latch_pc;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expired;

    assign w_misaligned = (direinstrux[1:0] != 2'b00);
    assign w_wd_enable  = (r_state == ST_WAIT);

    // flush wins over instr_ready so a redirected instruction never advances the PC
    assign w_accept = (r_state == ST_HOLD) && r_valid && instr_ready && !flush;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_drop_nxt;
            // HOLD is only ever entered through a capture, so valid tracks it
            r_valid <= (w_next == ST_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= RESET_INSTR;
            r_instr_pc <= '0;
        end else begin
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_latch_pc) begin
                r_instr_pc <= direinstrux;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_drop_nxt = r_drop;
        w_capture  = 1'b0;
        w_latch_pc = 1'b0;
        w_wd_clear = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next = ST_REQ;
            end

            ST_REQ: begin
                if (w_misaligned) begin
                    w_next = ST_ERR;
                end else if (imem_gnt) begin
                    w_next     = ST_WAIT;
                    w_latch_pc = 1'b1;
                    w_wd_clear = 1'b1;
                    // a redirect in the grant cycle makes this response stale
                    w_drop_nxt = flush;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_drop_nxt = 1'b0;
                    if (r_drop || flush) begin
                        w_next = ST_REQ;
                    end else begin
                        w_next    = ST_HOLD;
                        w_capture = 1'b1;
                    end
                end else if (w_wd_expired) begin
                    w_next     = ST_ERR;
                    w_drop_nxt = 1'b0;
                end else if (flush) begin
                    w_drop_nxt = 1'b1;
                end
            end

            ST_HOLD: begin
                if (flush || w_accept) begin
                    w_next = ST_REQ;
                end
            end

            ST_ERR: begin
                w_next = ST_ERR;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = (r_state == ST_REQ) && !w_misaligned;
    assign imem_addr   = (r_state == ST_REQ) ? direinstrux : '0;
    assign pc_en       = w_accept;
    assign instr_valid = r_valid;
    assign instr       = r_valid ? r_instr : RESET_INSTR;
    assign instr_pc    = r_instr_pc;
    assign fetch_err   = (r_state == ST_ERR);

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage directly downstream of the program-counter block. It takes the PC address (direinstrux) and fetches the word over a request/grant/response instruction-memory interface with variable latency. It presents the instruction to decode with a valid/ready handshake and issues a one-cycle pc_en pulse that allows the PC register to advance. It also discards stale responses on a redirect and flags misaligned or timed-out fetches.

Parameters:
ADDR_W, 32, address width (PC and imem_addr)
DATA_W, 32, instruction width
TIMEOUT, 15, max cycles in WAIT without imem_rvalid before error; 0 disables the watchdog
RESET_INSTR, 32'h0000_0000, value of instr while invalid (NOP, sll $0,$0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
direinstrux  in  ADDR_W  current PC from the pc block
flush  in  1  redirect: PC has been overwritten this cycle; drop any in-flight fetch
pc_en  out  1  one-cycle PC advance enable
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and no grant
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  DATA_W  response data
instr  out  DATA_W  fetched instruction
instr_pc  out  ADDR_W  address of instr
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts instr
fetch_err  out  1  sticky error (misaligned or timeout)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, imem_req=0, imem_addr=0, instr=RESET_INSTR, instr_pc=0, instr_valid=0, fetch_err=0. Watchdog count=0, drop flag=0. pc_en=0 during reset. Reset mid-transaction abandons it; a later imem_rvalid is ignored because the state is not WAIT.
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: moves to REQ on the next cycle.
- REQ:
  - If direinstrux[1:0]!=0: no request is issued; go to ERR and set fetch_err.
  - Otherwise imem_req=1 and imem_addr=direinstrux (combinational from PC).
  - On imem_gnt, latch the address into instr_pc and go to WAIT.
  - flush in REQ without imem_gnt: stay in REQ; the new PC appears on imem_addr next cycle.
  - flush with imem_gnt in the same cycle: go to WAIT with the drop flag set.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: capture imem_rdata into instr, set instr_valid=1, go to HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop, go to REQ.
  - flush in WAIT sets drop. flush together with imem_rvalid discards that data and goes to REQ.
  - Watchdog counts cycles in WAIT. When the count reaches TIMEOUT with no imem_rvalid: go to ERR, fetch_err=1.
- HOLD:
  - instr_valid=1; instr and instr_pc stable.
  - pc_en = instr_valid & instr_ready & !flush (combinational).
  - On accept (pc_en=1): instr_valid=0 next cycle, go to REQ. The PC has advanced on the same edge, so the next request uses the new PC.
  - flush in HOLD: instr_valid=0 next cycle, go to REQ, pc_en=0; flush wins over instr_ready.
- ERR: terminal until rst_n. imem_req=0, instr_valid=0, pc_en=0, fetch_err=1. flush is ignored.
- pc_en is asserted only in HOLD; at most one pulse per delivered instruction.
- imem_rvalid outside WAIT and imem_gnt outside REQ are ignored.
- Minimum latency: request at T with gnt at T, rvalid at T+1, instr_valid at T+2, pc_en at T+2 if ready. Next request at T+3, so peak throughput is one instruction per 3 cycles.
- Watchdog counter width is $clog2(TIMEOUT+1). It clears on every WAIT entry and saturates (no wrap).

Decomposition:
- Shared package (fetch_pkg): state enum (IDLE, REQ, WAIT, HOLD, ERR) and the NOP constant.
- One sub-module: fetch_watchdog (clear, enable, TIMEOUT parameter, expired output). The rest of the logic stays flat in inst_fetch.

Test Plan:
- Basic fetch: rst_n released, direinstrux=0x0000_0040, imem_gnt same cycle, rvalid next cycle with data 0x2008_0005, instr_ready=1 → instr_valid at T+2, instr=0x2008_0005, instr_pc=0x40, single pc_en pulse at T+2, next imem_addr=0x44.
- Backpressure: instr_ready held 0 for 5 cycles in HOLD → instr stable, pc_en=0 throughout; ready=1 → exactly one pc_en pulse.
- Flush while waiting: gnt at 0x40, flush during WAIT with direinstrux=0x100, rvalid 2 cycles later with 0xDEAD_BEEF → data discarded, instr_valid stays 0, next request at 0x100, then correct instruction delivered.
- Flush and ready together in HOLD: flush=1 and instr_ready=1 in the same cycle → pc_en=0, instr_valid drops, refetch from the new direinstrux.
- Misaligned PC: direinstrux=0x0000_0042 → imem_req never asserted, fetch_err=1 sticky; clears only when rst_n is asserted.
- Timeout: TIMEOUT=4, gnt with no rvalid → fetch_err=1 after 4 cycles in WAIT. A late rvalid is ignored; rst_n asserted mid-WAIT returns all outputs to reset values.
